// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader: loader and receiver
// state encodings, the frame sync byte and the instruction word size.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/uart_loader_if.sv
// Loader-to-CPU bundle: instruction memory write port plus core hold/status.
// mem_we is a one-cycle strobe with no back-pressure; the memory accepts every write.
interface uart_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;

    modport master (
        output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );

    modport slave (
        input mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );
endinterface

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver (module uart_rx): two-flop synchronizer, start-glitch
// rejection at the half-bit point, mid-bit sampling, one-cycle byte_valid pulse.
module uart_rx
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output rx_state_t  dbg_state
);
    localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic          meta_q, sync_q, prev_q;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_BITS;
                end
            end
            RX_BITS: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    ferr_d  = !sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_data  = shift_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;
    assign dbg_state  = state_q;

endmodule

// File: rtl/uart_loader.sv
// UART boot loader: parses A5/len/data[/csum] frames and writes instruction memory.
// UART_LOADER_CHECKSUM_EN enables the trailing checksum byte and its CSUM state.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    uart_loader_if.master bus,
    output loader_state_t dbg_state,
    output rx_state_t     dbg_rx_state
);
    localparam int          CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam logic [16:0] MAX_WORDS    = 17'(2 ** ADDR_WIDTH);
    localparam int          LW           = $clog2(WORD_BYTES);
    localparam int          AW_BITS      = 8 * (WORD_BYTES - 1);
`ifdef UART_LOADER_CHECKSUM_EN
    localparam loader_state_t END_STATE = CSUM;
`else
    localparam loader_state_t END_STATE = DONE;
`endif

    logic [7:0] byte_data;
    logic       byte_valid, frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .dbg_state (dbg_rx_state)
    );

    loader_state_t         state_q, state_d;
    logic [15:0]           len_q, len_d, widx_q, widx_d, n_words;
    logic [LW-1:0]         lane_q, lane_d;
    logic [AW_BITS-1:0]    word_q, word_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_error_q, load_error_d;

    assign n_words = {byte_data, len_q[7:0]};

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Restarted on every byte outside a frame, so it is zero when A5 opens one.
    always_comb begin
        csum_d = csum_q;
        if (byte_valid) begin
            if (state_q inside {SYNC, DONE, ERROR})        csum_d = '0;
            else if (state_q inside {LEN_LO, LEN_HI, DATA}) csum_d = csum_q + byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            len_q        <= '0;
            widx_q       <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            widx_q       <= widx_d;
            lane_q       <= lane_d;
            word_q       <= word_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        widx_d      = widx_q;
        lane_d      = lane_q;
        word_d      = word_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (byte_valid) begin
            case (state_q)
                SYNC, DONE, ERROR: begin
                    if (!frame_err && byte_data == SYNC_BYTE) state_d = LEN_LO;
                end
                LEN_LO: begin
                    len_d   = {8'h00, byte_data};
                    state_d = frame_err ? ERROR : LEN_HI;
                end
                LEN_HI: begin
                    len_d  = n_words;
                    widx_d = '0;
                    lane_d = '0;
                    if (frame_err || ({1'b0, n_words} > MAX_WORDS)) state_d = ERROR;
                    else if (n_words == 16'd0)                      state_d = END_STATE;
                    else                                            state_d = DATA;
                end
                DATA: begin
                    if (frame_err) begin
                        state_d = ERROR;
                    end else if (lane_q == LW'(WORD_BYTES - 1)) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = widx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {byte_data, word_q};
                        widx_d      = widx_q + 16'd1;
                        lane_d      = '0;
                        if (widx_q == len_q - 16'd1) state_d = END_STATE;
                    end else begin
                        word_d = {byte_data, word_q[AW_BITS-1:8]};
                        lane_d = lane_q + LW'(1);
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                CSUM: begin
                    state_d = (!frame_err && byte_data == csum_q) ? DONE : ERROR;
                end
`endif
                default: state_d = SYNC;
            endcase
        end
        // Status flags are pure functions of the state being entered.
        load_done_d  = (state_d == DONE);
        cpu_hold_d   = (state_d != DONE);
        load_error_d = (state_d == ERROR);
    end

    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_error = load_error_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: serial frame driver, frame-level reference model and
// write scoreboard; directed test-plan scenarios followed by random frames.
module tb_uart_loader;
  import uart_loader_pkg::*;

  localparam int CPB = 8;
  localparam int AW  = 10;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_WIDTH(AW)) bus ();
  loader_state_t dbg_state;
  rx_state_t     dbg_rx_state;

  uart_loader #(.CLK_FREQ_HZ(800), .BAUD(100), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .bus         (bus),
    .dbg_state   (dbg_state),
    .dbg_rx_state(dbg_rx_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: expected {addr, data} writes in order
  logic [AW+31:0] exp_q[$];
  logic           we_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      check("we_single_cycle", 64'(we_prev), 64'(0));
      check("write_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(e[AW+31:32]));
        check("wr_data", 64'(bus.mem_wdata), 64'(e[31:0]));
      end
    end
    we_prev <= bus.mem_we;
  end

  // frame under construction
  logic [7:0]  fr_q[$];
  logic [31:0] words[$];

  task automatic build_frame(input int n, input bit bad_csum);
    int s;
    fr_q.delete();
    fr_q.push_back(8'hA5);
    fr_q.push_back(n[7:0]);
    fr_q.push_back(n[15:8]);
    if (n <= (1 << AW)) begin
      for (int k = 0; k < n; k++)
        for (int b = 0; b < 4; b++) fr_q.push_back(words[k][8*b +: 8]);
      if (CSUM_EN) begin
        s = 0;
        for (int i = 1; i < fr_q.size(); i++) s += fr_q[i];
        s = (s + (bad_csum ? 1 : 0)) % 256;
        fr_q.push_back(s[7:0]);
      end
    end
  endtask

  // reference model: which words land in memory and how the frame ends
  task automatic model_frame(input int n, input int fe_pos, input bit bad_csum,
                             output bit exp_done, output bit exp_err);
    if (n > (1 << AW)) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      return;
    end
    for (int k = 0; k < n; k++)
      if (fe_pos < 0 || (6 + 4 * k) < fe_pos) exp_q.push_back({AW'(k), words[k]});
    exp_err  = (fe_pos >= 0) || (CSUM_EN && bad_csum);
    exp_done = !exp_err;
  endtask

  // drivers
  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_garbage(input int cnt);
    logic [7:0] g;
    for (int i = 0; i < cnt; i++) begin
      do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
      send_byte(g, 1'b1);
    end
  endtask

  task automatic run_frame(input string tag, input int n, input int fe_pos, input bit bad_csum);
    bit exp_done, exp_err;
    build_frame(n, bad_csum);
    model_frame(n, fe_pos, bad_csum, exp_done, exp_err);
    for (int i = 0; i < fr_q.size(); i++) begin
      send_byte(fr_q[i], i != fe_pos);
      if (i == fe_pos) break;
      if (i == 0) begin
        idle(2);
        check({tag, "_hold_after_sync"}, 64'(bus.cpu_hold), 64'(1));
        check({tag, "_done_after_sync"}, 64'(bus.load_done), 64'(0));
      end else if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, CPB));
      end
    end
    idle(3);
    check({tag, "_load_done"}, 64'(bus.load_done), 64'(exp_done));
    check({tag, "_load_error"}, 64'(bus.load_error), 64'(exp_err));
    check({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(!exp_done));
    check({tag, "_state"}, 64'(dbg_state), 64'(exp_done ? DONE : ERROR));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(1));
    check({tag, "_mem_we"}, 64'(bus.mem_we), 64'(0));
    check({tag, "_load_done"}, 64'(bus.load_done), 64'(0));
    check({tag, "_load_error"}, 64'(bus.load_error), 64'(0));
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(0));
    check({tag, "_state"}, 64'(dbg_state), 64'(SYNC));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_reset_values(tag);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check({tag, "_hold_idle"}, 64'(bus.cpu_hold), 64'(1));
  endtask

  initial begin
    int n, fe, mode;
    bit bad;

    // power-on reset
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    idle(4);
    check("por_hold_idle", 64'(bus.cpu_hold), 64'(1));

    // reference program, good and corrupted checksum
    words = '{32'h0010_0013, 32'h0FF0_0093};
    run_frame("prog_ok", 2, -1, 1'b0);
    idle(2 * CPB);
    run_frame("prog_badsum", 2, -1, 1'b1);
    idle(2 * CPB);

    // leading noise bytes, then an empty image
    pulse_reset("rst1");
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    words.delete();
    run_frame("empty", 0, -1, 1'b0);
    idle(2 * CPB);

    // oversized length, then a normal frame recovers
    words.delete();
    run_frame("oversize", 16'h0401, -1, 1'b0);
    words = '{32'hDEAD_BEEF};
    run_frame("after_oversize", 1, -1, 1'b0);
    idle(2 * CPB);

    // framing error on word 1, lane 1: word 0 lands, word 1 does not
    words = '{32'h1111_2222, 32'h3333_4444};
    run_frame("frame_err", 2, 8, 1'b0);
    idle(2 * CPB);

    // single-cycle low glitch right before a frame must not steal its start
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    idle(2 * CPB);
    words = '{32'hCAFE_F00D, 32'h0000_0001};
    run_frame("after_glitch", 2, -1, 1'b0);

    // reset during the third data byte
    words = '{32'h0010_0013, 32'h0FF0_0093};
    build_frame(2, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(fr_q[i], 1'b1);
    fork
      send_byte(fr_q[5], 1'b1);
      begin
        repeat (3 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_values("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    idle(20 * CPB);
    check("mid_rst_no_writes", 64'(exp_q.size()), 64'(0));
    check("mid_rst_state", 64'(dbg_state), 64'(SYNC));
    check("mid_rst_hold", 64'(bus.cpu_hold), 64'(1));
    run_frame("after_rst", 2, -1, 1'b0);

    // random frames
    for (int r = 0; r < 10; r++) begin
      send_garbage($urandom_range(0, 2));
      mode = $urandom_range(0, 9);
      n = $urandom_range(0, 4);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
      fe = -1;
      bad = 1'b0;
      if (mode == 9) begin
        n = 1025 + $urandom_range(0, 200);
      end else if (mode <= 1) begin
        build_frame(n, 1'b0);
        fe = $urandom_range(1, fr_q.size() - 1);
      end else if (mode == 2) begin
        bad = 1'b1;
      end
      run_frame($sformatf("rand%0d", r), n, fe, bad);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2 * CPB));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
